branch_resolve_queue: RTL and testbench

- In-order FIFO of in-flight branch predictions. It sits directly downstream of the global branch predictor.
- At fetch it records the predictor's taken/not-taken decision plus the predicted target. At execute it compares the oldest entry against the resolved outcome.
- It then drives the predictor's update pulse, the mispredict flag and the fetch redirect/flush.

---
 rtl/branch_resolve_queue_pkg.sv | 12 +
 rtl/bq_fifo_mem.sv | 28 ++
 rtl/branch_resolve_queue.sv | 121 ++++++++++++
 tb/tb_branch_resolve_queue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_queue_pkg.sv
// Shared branch-predictor types: the in-flight prediction record and instruction size.
package branch_resolve_queue_pkg;

    localparam int unsigned BR_INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } bq_entry_t;

endpackage

// File: rtl/bq_fifo_mem.sv
// DEPTH-entry prediction store: one synchronous write port, combinational read of the head.
module bq_fifo_mem
    import branch_resolve_queue_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  bq_entry_t        i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output bq_entry_t        o_rdata
);

    bq_entry_t r_mem [DEPTH];

    // NOTE: the array is deliberately not reset; an entry is only read after
    // count says it was written, so its power-up contents never matter.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions; checks the oldest against the
// resolved outcome and emits predictor update, mispredict and fetch redirect pulses.
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq_valid,
    input  logic [31:0]      enq_pc,
    input  logic             enq_pred_taken,
    input  logic [31:0]      enq_pred_target,
    output logic             enq_ready,
    input  logic             res_valid,
    input  logic [31:0]      res_pc,
    input  logic             res_br_en,
    input  logic [31:0]      res_target,
    output logic             pred_update,
    output logic             upd_br_en,
    output logic [31:0]      upd_pc,
    output logic             mis_predict,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [PTR_W:0]   count,
    output logic             proto_err
);

    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_pred_update, r_upd_br_en, r_mis_predict, r_redirect_valid, r_proto_err;
    logic [31:0]      r_upd_pc, r_redirect_pc;

    logic [PTR_W-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_enq_fire, w_res_fire, w_mispredict, w_proto_hit, w_mem_we;
    logic [31:0]      w_redirect_pc;
    bq_entry_t        w_head, w_enq_entry;

    assign w_enq_fire  = enq_valid && enq_ready;
    assign w_res_fire  = res_valid && (r_count != '0);
    assign w_enq_entry = '{pc: enq_pc, pred_taken: enq_pred_taken, pred_target: enq_pred_target};
    // A mispredict flushes everything younger, including a same-cycle enqueue.
    assign w_mem_we    = w_enq_fire && !w_mispredict;

    bq_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_enq_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    assign w_mispredict = w_res_fire &&
                          ((w_head.pred_taken != res_br_en) ||
                           (res_br_en && (w_head.pred_target != res_target)));
    assign w_proto_hit  = res_valid && ((r_count == '0) || (res_pc != w_head.pc));
    assign w_redirect_pc = res_br_en ? res_target : res_pc + 32'(BR_INSTR_BYTES);

    // NOTE: next-state logic is pure combinational; every output gets a default
    // before any branch so no path leaves a value unassigned (no latches).
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (w_mispredict) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            if (w_enq_fire) w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
            if (w_res_fire) w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
            w_count_nxt = r_count + CNT_W'(w_enq_fire) - CNT_W'(w_res_fire);
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_pred_update    <= 1'b0;
            r_upd_br_en      <= 1'b0;
            r_upd_pc         <= '0;
            r_mis_predict    <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_proto_err      <= 1'b0;
        end else begin
            r_wr_ptr         <= w_wr_ptr_nxt;
            r_rd_ptr         <= w_rd_ptr_nxt;
            r_count          <= w_count_nxt;
            r_pred_update    <= w_res_fire;
            r_mis_predict    <= w_mispredict;
            r_redirect_valid <= w_mispredict;
            if (w_res_fire) begin
                r_upd_br_en <= res_br_en;
                r_upd_pc    <= res_pc;
            end
            if (w_mispredict) r_redirect_pc <= w_redirect_pc;
            if (w_proto_hit)  r_proto_err   <= 1'b1;
        end
    end

    assign enq_ready      = (r_count != CNT_W'(DEPTH));
    assign count          = r_count;
    assign pred_update    = r_pred_update;
    assign upd_br_en      = r_upd_br_en;
    assign upd_pc         = r_upd_pc;
    assign mis_predict    = r_mis_predict;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign proto_err      = r_proto_err;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue (DEPTH=8).
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid, enq_pred_taken, enq_ready;
    logic [31:0] enq_pc, enq_pred_target;
    logic        res_valid, res_br_en;
    logic [31:0] res_pc, res_target;
    logic        pred_update, upd_br_en, mis_predict, redirect_valid, proto_err;
    logic [31:0] upd_pc, redirect_pc;
    logic [3:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    branch_resolve_queue #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_pred_taken(enq_pred_taken),
        .enq_pred_target(enq_pred_target), .enq_ready(enq_ready),
        .res_valid(res_valid), .res_pc(res_pc), .res_br_en(res_br_en), .res_target(res_target),
        .pred_update(pred_update), .upd_br_en(upd_br_en), .upd_pc(upd_pc),
        .mis_predict(mis_predict), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .count(count), .proto_err(proto_err)
    );

    // Advance one edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enq_valid = 0; enq_pc = '0; enq_pred_taken = 0; enq_pred_target = '0;
        res_valid = 0; res_pc = '0; res_br_en = 0; res_target = '0;
    endtask

    task automatic set_enq(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        enq_valid = 1; enq_pc = pc; enq_pred_taken = pt; enq_pred_target = tgt;
    endtask

    task automatic set_res(input logic [31:0] pc, input logic br, input logic [31:0] tgt);
        res_valid = 1; res_pc = pc; res_br_en = br; res_target = tgt;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        repeat (3) step();
        rst = 1;
        step();
        n_cmp++; if (count !== 4'd0)          begin n_bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_cmp++; if (enq_ready !== 1'b1)      begin n_bad++; $display("FAIL reset_enq_ready got=%b exp=1", enq_ready); end
        n_cmp++; if ({pred_update, mis_predict, redirect_valid, proto_err} !== 4'b0)
                                              begin n_bad++; $display("FAIL reset_pulses got=%b exp=0000", {pred_update, mis_predict, redirect_valid, proto_err}); end
        n_cmp++; if (redirect_pc !== 32'h0)   begin n_bad++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); end
    endtask

    task automatic test_correct_not_taken();
        set_enq(32'h100, 0, 32'h0);
        step();
        idle_inputs();
        set_res(32'h100, 0, 32'h0);
        step();
        idle_inputs();
        n_cmp++; if (pred_update !== 1'b1)    begin n_bad++; $display("FAIL nt_pred_update got=%b exp=1", pred_update); end
        n_cmp++; if (upd_pc !== 32'h100)      begin n_bad++; $display("FAIL nt_upd_pc got=%h exp=100", upd_pc); end
        n_cmp++; if (upd_br_en !== 1'b0)      begin n_bad++; $display("FAIL nt_upd_br_en got=%b exp=0", upd_br_en); end
        n_cmp++; if (mis_predict !== 1'b0 || redirect_valid !== 1'b0)
                                              begin n_bad++; $display("FAIL nt_no_redirect got=%b%b exp=00", mis_predict, redirect_valid); end
        n_cmp++; if (count !== 4'd0)          begin n_bad++; $display("FAIL nt_count got=%0d exp=0", count); end
        step();
        n_cmp++; if (pred_update !== 1'b0)    begin n_bad++; $display("FAIL nt_pulse_width got=%b exp=0", pred_update); end
    endtask

    task automatic test_direction_mispredict();
        set_enq(32'h100, 0, 32'h0); step();
        set_enq(32'h104, 0, 32'h0); step();
        set_enq(32'h108, 0, 32'h0); step();
        n_cmp++; if (count !== 4'd3)          begin n_bad++; $display("FAIL dir_fill_count got=%0d exp=3", count); end
        set_enq(32'h10C, 0, 32'h0);
        set_res(32'h100, 1, 32'h200);
        step();
        idle_inputs();
        n_cmp++; if (redirect_valid !== 1'b1 || mis_predict !== 1'b1)
                                              begin n_bad++; $display("FAIL dir_redirect got=%b%b exp=11", redirect_valid, mis_predict); end
        n_cmp++; if (redirect_pc !== 32'h200) begin n_bad++; $display("FAIL dir_redirect_pc got=%h exp=200", redirect_pc); end
        n_cmp++; if (pred_update !== 1'b1 || upd_br_en !== 1'b1)
                                              begin n_bad++; $display("FAIL dir_update got=%b%b exp=11", pred_update, upd_br_en); end
        n_cmp++; if (count !== 4'd0)          begin n_bad++; $display("FAIL dir_flush_count got=%0d exp=0", count); end
        step();
        n_cmp++; if (count !== 4'd0 || redirect_valid !== 1'b0)
                                              begin n_bad++; $display("FAIL dir_enq_dropped count=%0d rv=%b exp=0/0", count, redirect_valid); end
    endtask

    task automatic test_target_redirects();
        // Taken, wrong target.
        set_enq(32'h500, 1, 32'h300); step();
        idle_inputs(); set_res(32'h500, 1, 32'h340); step();
        idle_inputs();
        n_cmp++; if (mis_predict !== 1'b1 || redirect_pc !== 32'h340)
                                              begin n_bad++; $display("FAIL tgt_mispredict mp=%b pc=%h exp=1/340", mis_predict, redirect_pc); end
        // Predicted taken, actually not taken: fall through.
        set_enq(32'h400, 1, 32'h480); step();
        idle_inputs(); set_res(32'h400, 0, 32'h999); step();
        idle_inputs();
        n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h404)
                                              begin n_bad++; $display("FAIL nt_redirect rv=%b pc=%h exp=1/404", redirect_valid, redirect_pc); end
        // Fall-through wraps at the top of the address space.
        set_enq(32'hFFFF_FFFC, 1, 32'h10); step();
        idle_inputs(); set_res(32'hFFFF_FFFC, 0, 32'h10); step();
        idle_inputs();
        n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0)
                                              begin n_bad++; $display("FAIL wrap_redirect rv=%b pc=%h exp=1/0", redirect_valid, redirect_pc); end
        // Taken with the right target: no redirect.
        set_enq(32'h600, 1, 32'h700); step();
        idle_inputs(); set_res(32'h600, 1, 32'h700); step();
        idle_inputs();
        n_cmp++; if (pred_update !== 1'b1 || mis_predict !== 1'b0 || redirect_valid !== 1'b0)
                                              begin n_bad++; $display("FAIL taken_ok got=%b%b%b exp=100", pred_update, mis_predict, redirect_valid); end
        step();
    endtask

    task automatic test_full_wrap();
        int next_in;
        int exp_cnt;
        for (int i = 0; i < 8; i++) begin
            set_enq(32'h1000 + 32'(4 * i), i[0], 32'h2000 + 32'(4 * i));
            step();
        end
        n_cmp++; if (count !== 4'd8 || enq_ready !== 1'b0)
                                              begin n_bad++; $display("FAIL full count=%0d ready=%b exp=8/0", count, enq_ready); end
        set_enq(32'h9999, 0, 32'h0);
        step();
        n_cmp++; if (count !== 4'd8)          begin n_bad++; $display("FAIL full_extra_enq count=%0d exp=8", count); end
        next_in = 8;
        exp_cnt = 8;
        for (int k = 0; k < 12; k++) begin
            // Enqueue is refused only while the pre-pop count is DEPTH.
            set_enq(32'h1000 + 32'(4 * next_in), next_in[0], 32'h2000 + 32'(4 * next_in));
            set_res(32'h1000 + 32'(4 * k), k[0], 32'h2000 + 32'(4 * k));
            if (exp_cnt != 8) next_in++;
            else exp_cnt--;
            step();
            n_cmp++; if (pred_update !== 1'b1 || mis_predict !== 1'b0 || upd_pc !== 32'h1000 + 32'(4 * k))
                begin n_bad++; $display("FAIL wrap_order k=%0d upd=%b mp=%b pc=%h exp=1/0/%h", k, pred_update, mis_predict, upd_pc, 32'h1000 + 32'(4 * k)); end
            n_cmp++; if (count !== 4'(exp_cnt))
                begin n_bad++; $display("FAIL wrap_count k=%0d got=%0d exp=%0d", k, count, exp_cnt); end
        end
        // Head is entry 12 (pred_taken=0); resolving taken flushes the rest.
        idle_inputs();
        set_res(32'h1000 + 32'(4 * 12), 1, 32'h40);
        step();
        idle_inputs();
        n_cmp++; if (count !== 4'd0 || redirect_pc !== 32'h40)
                                              begin n_bad++; $display("FAIL wrap_drain count=%0d pc=%h exp=0/40", count, redirect_pc); end
        step();
    endtask

    task automatic test_protocol_errors();
        n_cmp++; if (proto_err !== 1'b0)      begin n_bad++; $display("FAIL proto_clean got=%b exp=0", proto_err); end
        set_res(32'h100, 0, 32'h0); step();
        idle_inputs();
        n_cmp++; if (proto_err !== 1'b1 || pred_update !== 1'b0 || count !== 4'd0)
                                              begin n_bad++; $display("FAIL proto_empty err=%b upd=%b cnt=%0d exp=1/0/0", proto_err, pred_update, count); end
        set_enq(32'h700, 0, 32'h0); step();
        idle_inputs(); set_res(32'h704, 0, 32'h0); step();
        idle_inputs();
        n_cmp++; if (pred_update !== 1'b1 || upd_pc !== 32'h704 || mis_predict !== 1'b0 || count !== 4'd0)
                                              begin n_bad++; $display("FAIL proto_pc_mismatch upd=%b pc=%h mp=%b cnt=%0d exp=1/704/0/0", pred_update, upd_pc, mis_predict, count); end
        repeat (4) step();
        n_cmp++; if (proto_err !== 1'b1)      begin n_bad++; $display("FAIL proto_sticky got=%b exp=1", proto_err); end
    endtask

    task automatic test_reset_mid_op();
        set_enq(32'h800, 0, 32'h0); step();
        set_enq(32'h804, 0, 32'h0); step();
        idle_inputs(); set_res(32'h800, 1, 32'h900); step();
        idle_inputs();
        n_cmp++; if (redirect_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_pre rv=%b exp=1", redirect_valid); end
        #1 rst = 0;
        #1;
        n_cmp++; if ({redirect_valid, mis_predict, pred_update, proto_err} !== 4'b0 || count !== 4'd0 || redirect_pc !== 32'h0)
                                              begin n_bad++; $display("FAIL midrst_async flags=%b cnt=%0d pc=%h exp=0000/0/0", {redirect_valid, mis_predict, pred_update, proto_err}, count, redirect_pc); end
        step();
        rst = 1;
        step();
        n_cmp++; if (enq_ready !== 1'b1 || proto_err !== 1'b0)
                                              begin n_bad++; $display("FAIL midrst_release ready=%b err=%b exp=1/0", enq_ready, proto_err); end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        #2;
        test_reset();
        test_correct_not_taken();
        test_direction_mispredict();
        test_target_redirects();
        test_full_wrap();
        test_protocol_errors();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
